// File: rtl/score_keeper.sv
// ----------------------------------------------------------------------------
// score_keeper : goal counting, serve sequencing and winner latch for the game
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module score_keeper #(
  parameter int MAX_SCORE_W = 4,
  parameter int MAX_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter int DELAY_W     = $clog2(SERVE_DELAY + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   game_start_i,
  input  logic                   frame_tick_i,
  input  logic                   p_goal_i,
  input  logic                   e_goal_i,
  output logic [MAX_SCORE_W-1:0] p_score_o,
  output logic [MAX_SCORE_W-1:0] e_score_o,
  output logic                   ball_hold_o,
  output logic                   serve_o,
  output logic                   serve_dir_o,
  output logic                   p_win_o,
  output logic                   e_win_o
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SERVE_WAIT = 2'd1;
  localparam logic [1:0] ST_PLAY       = 2'd2;
  localparam logic [1:0] ST_GAME_OVER  = 2'd3;

  localparam logic [MAX_SCORE_W-1:0] C_MAX_SCORE = MAX_SCORE_W'(MAX_SCORE);
  localparam logic [MAX_SCORE_W-1:0] C_SCORE_ONE = MAX_SCORE_W'(1);
  localparam logic [DELAY_W-1:0]     C_DELAY     = DELAY_W'(SERVE_DELAY);
  localparam logic [DELAY_W-1:0]     C_DELAY_ONE = DELAY_W'(1);

  logic [1:0]             state_q, state_d;
  logic [DELAY_W-1:0]     cnt_q, cnt_d;
  logic [MAX_SCORE_W-1:0] p_score_q, p_score_d;
  logic [MAX_SCORE_W-1:0] e_score_q, e_score_d;
  logic                   dir_q, dir_d;
  logic                   p_win_q, p_win_d;
  logic                   e_win_q, e_win_d;
  logic                   hold_q, hold_d;
  logic                   serve_q, serve_d;
  logic [MAX_SCORE_W-1:0] w_p_inc;
  logic [MAX_SCORE_W-1:0] w_e_inc;

  assign w_p_inc = p_score_q + C_SCORE_ONE;
  assign w_e_inc = e_score_q + C_SCORE_ONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state together with the score/pause datapath; game_start_i outranks everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_score_d = p_score_q;
    e_score_d = e_score_q;
    dir_d     = dir_q;
    p_win_d   = p_win_q;
    e_win_d   = e_win_q;
    if (game_start_i) begin
      state_d   = ST_SERVE_WAIT;
      cnt_d     = C_DELAY;
      p_score_d = '0;
      e_score_d = '0;
      dir_d     = 1'b0;
      p_win_d   = 1'b0;
      e_win_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SERVE_WAIT: begin
          if (frame_tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - C_DELAY_ONE;
            if (cnt_q == C_DELAY_ONE) begin
              state_d = ST_PLAY;
            end
          end
        end
        ST_PLAY: begin
          if (p_goal_i || e_goal_i) begin
            cnt_d   = C_DELAY;
            state_d = ST_SERVE_WAIT;
            if (p_goal_i && !e_goal_i) begin
              p_score_d = w_p_inc;
              dir_d     = 1'b0;
              if (w_p_inc == C_MAX_SCORE) begin
                state_d = ST_GAME_OVER;
                p_win_d = 1'b1;
              end
            end else if (e_goal_i && !p_goal_i) begin
              e_score_d = w_e_inc;
              dir_d     = 1'b1;
              if (w_e_inc == C_MAX_SCORE) begin
                state_d = ST_GAME_OVER;
                e_win_d = 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Serve fires only on the SERVE_WAIT to PLAY transition.
  always_comb begin
    hold_d  = (state_d != ST_PLAY);
    serve_d = (state_q == ST_SERVE_WAIT) && (state_d == ST_PLAY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      p_score_q <= '0;
      e_score_q <= '0;
      dir_q     <= 1'b0;
      p_win_q   <= 1'b0;
      e_win_q   <= 1'b0;
      hold_q    <= 1'b1;
      serve_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_score_q <= p_score_d;
      e_score_q <= e_score_d;
      dir_q     <= dir_d;
      p_win_q   <= p_win_d;
      e_win_q   <= e_win_d;
      hold_q    <= hold_d;
      serve_q   <= serve_d;
    end
  end

  assign p_score_o   = p_score_q;
  assign e_score_o   = e_score_q;
  assign ball_hold_o = hold_q;
  assign serve_o     = serve_q;
  assign serve_dir_o = dir_q;
  assign p_win_o     = p_win_q;
  assign e_win_o     = e_win_q;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ----------------------------------------------------------------------------
// tb_score_keeper : scoreboard bench for score_keeper
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p_goal = 1'b0;
  logic       e_goal = 1'b0;
  logic [3:0] p_score;
  logic [3:0] e_score;
  logic       ball_hold;
  logic       serve;
  logic       serve_dir;
  logic       p_win;
  logic       e_win;
  logic [12:0] obs;

  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] obs_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .game_start_i (game_start),
    .frame_tick_i (frame_tick),
    .p_goal_i     (p_goal),
    .e_goal_i     (e_goal),
    .p_score_o    (p_score),
    .e_score_o    (e_score),
    .ball_hold_o  (ball_hold),
    .serve_o      (serve),
    .serve_dir_o  (serve_dir),
    .p_win_o      (p_win),
    .e_win_o      (e_win)
  );

  assign obs = {p_score, e_score, ball_hold, serve, serve_dir, p_win, e_win};

  // {p_score, e_score, hold, serve, dir, p_win, e_win}
  function automatic logic [12:0] ev(input int p, input int e, input logic h,
                                     input logic s, input logic d,
                                     input logic pw, input logic ew);
    return {4'(p), 4'(e), h, s, d, pw, ew};
  endfunction

  task automatic step(input logic st, input logic tk, input logic pg, input logic eg);
    game_start = st;
    frame_tick = tk;
    p_goal     = pg;
    e_goal     = eg;
    @(posedge clk);
    #1;
    game_start = 1'b0;
    frame_tick = 1'b0;
    p_goal     = 1'b0;
    e_goal     = 1'b0;
  endtask

  task automatic step_x(input logic st, input logic tk, input logic pg, input logic eg,
                        input string nm, input logic [12:0] e);
    exp_t x;
    x.name = nm;
    x.v    = e;
    exp_q.push_back(x);
    step(st, tk, pg, eg);
    obs_q.push_back(obs);
  endtask

  task automatic rally();
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Score bounds and mutually exclusive win flags, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (p_score > 4'd9 || e_score > 4'd9 || (p_win && e_win)) begin
        miscompares++;
        $display("FAIL invariant: p=%0d e=%0d pw=%b ew=%b required scores<=9 and not both wins",
                 p_score, e_score, p_win, e_win);
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    logic [12:0] o;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back('{"reset_state", ev(0, 0, 1, 0, 0, 0, 0)});
    obs_q.push_back(obs);
    rst_n = 1'b1;
    step_x(0, 0, 1, 0, "idle_p_goal", ev(0, 0, 1, 0, 0, 0, 0));
    step_x(0, 0, 0, 1, "idle_e_goal", ev(0, 0, 1, 0, 0, 0, 0));
    step_x(0, 1, 0, 0, "idle_tick",   ev(0, 0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_serve();
    exp_t e;
    logic [12:0] o;
    int n = 0;
    step_x(1, 0, 0, 0, "start", ev(0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 59; i++) begin
      step(0, 1, 0, 0);
      if (serve !== 1'b0 || ball_hold !== 1'b1) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL early_serve: got %0d bad cycles expected 0", n);
    end
    step_x(0, 1, 0, 0, "serve_60th_tick", ev(0, 0, 0, 1, 0, 0, 0));
    step_x(0, 0, 0, 0, "serve_one_cycle", ev(0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_goal();
    exp_t e;
    logic [12:0] o;
    int n = 0;
    step_x(0, 0, 1, 0, "p_goal", ev(1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
    step_x(0, 0, 1, 1, "wait_both_goals", ev(1, 0, 1, 0, 0, 0, 0));
    step_x(0, 0, 0, 1, "wait_e_goal",     ev(1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 29; i++) begin
      step(0, 1, 0, 0);
      if (serve !== 1'b0) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL no_reload_early_serve: got %0d serves expected 0", n);
    end
    step_x(0, 1, 0, 0, "no_reload_serve", ev(1, 0, 0, 1, 0, 0, 0));
    step_x(0, 0, 0, 1, "e_goal", ev(1, 1, 1, 0, 1, 0, 0));
    rally();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_both_goals();
    exp_t e;
    logic [12:0] o;
    step_x(0, 0, 1, 0, "p_goal_2_1", ev(2, 1, 1, 0, 0, 0, 0));
    rally();
    step_x(0, 0, 1, 0, "p_goal_3_1", ev(3, 1, 1, 0, 0, 0, 0));
    rally();
    step_x(0, 0, 0, 1, "e_goal_3_2", ev(3, 2, 1, 0, 1, 0, 0));
    rally();
    step_x(0, 0, 1, 1, "both_replay", ev(3, 2, 1, 0, 1, 0, 0));
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
    step_x(0, 1, 0, 0, "replay_serve", ev(3, 2, 0, 1, 1, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_win();
    exp_t e;
    logic [12:0] o;
    int n = 0;
    for (int k = 3; k <= 8; k++) begin
      step_x(0, 0, 0, 1, "e_goal_climb", ev(3, k, 1, 0, 1, 0, 0));
      rally();
    end
    step_x(0, 0, 0, 1, "e_wins",        ev(3, 9, 1, 0, 1, 0, 1));
    step_x(0, 0, 1, 0, "over_p_goal",   ev(3, 9, 1, 0, 1, 0, 1));
    step_x(0, 0, 0, 1, "over_e_goal",   ev(3, 9, 1, 0, 1, 0, 1));
    for (int i = 0; i < 70; i++) begin
      step(0, 1, 0, 0);
      if (serve !== 1'b0) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL over_serve: got %0d serves expected 0", n);
    end
    step_x(0, 0, 0, 0, "over_hold",     ev(3, 9, 1, 0, 1, 0, 1));
    step_x(1, 0, 1, 1, "restart",       ev(0, 0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.v);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [12:0] o;
    int n = 0;
    rally();
    step_x(0, 0, 1, 0, "pre_reset_goal", ev(1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('{"async_reset", ev(0, 0, 1, 0, 0, 0, 0)});
    obs_q.push_back(obs);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      step(0, 1, 0, 0);
      if (serve !== 1'b0) n++;
    end
    vectors++;
    if (n !== 0) begin
      miscompares++;
      $display("FAIL post_reset_serve: got %0d serves expected 0", n);
    end
    step_x(0, 0, 0, 0, "post_reset_idle", ev(0, 0, 1, 0, 0, 0, 0));
    step_x(1, 0, 0, 0, "post_reset_start", ev(0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
    step_x(0, 1, 0, 0, "post_reset_serve", ev(0, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_goal();
    test_both_goals();
    test_win();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
